// File: rtl/dphy_pkg.sv
// -----------------------------------------------------------------------------
// dphy_pkg
// Shared definitions for the D-PHY PLL lock manager:
//   - default parameter values for dphy_pll_mgr
//   - FSM state encoding (this value is also driven out on STATE)
//   - PLL control bundle and a helper that maps each state to its control levels
//   - small constant helpers used to size counters and ports
// -----------------------------------------------------------------------------
package dphy_pkg;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_LOCK_FILT    = 64;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_SYNC_STAGES  = 2;

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Control levels that depend only on the state being entered.
  typedef struct packed {
    logic resetb;
    logic bypass;
    logic ready;
    logic fault;
  } pll_ctl_t;

  function automatic pll_ctl_t ctl_for(input state_t st);
    pll_ctl_t c;
    c.resetb = (st == ST_WAIT_LOCK) || (st == ST_FILTER) || (st == ST_LOCKED);
    c.bypass = (st == ST_FAULT);
    c.ready  = (st == ST_LOCKED);
    c.fault  = (st == ST_FAULT);
    return c;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // RETRY_CNT width; MAX_RETRY=0 would otherwise give a zero-width port.
  function automatic int retry_w(input int max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/dphy_sync.sv
// -----------------------------------------------------------------------------
// dphy_sync
// Multi-flop synchroniser bringing the asynchronous PLL LOCK into the CLK domain.
// Ports:
//   clk    - destination clock
//   resetn - synchronous active-low reset, clears every stage
//   d      - asynchronous input
//   q      - synchronised output (last stage)
// -----------------------------------------------------------------------------
module dphy_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ff_reg <= '0;
    end else begin
      ff_reg <= {ff_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff_reg[SYNC_STAGES-1];

endmodule

// File: rtl/dphy_pll_mgr.sv
// -----------------------------------------------------------------------------
// dphy_pll_mgr
// Sequences a D-PHY PLL through reset, lock acquisition, lock filtering and
// steady-state monitoring, retrying on lock timeout and latching a fault once
// the retry budget is spent.
// Ports:
//   CLK        - free-running reference clock (only clock)
//   RESET      - synchronous active-low reset
//   RESTART    - one-cycle request to restart the lock sequence
//   PLL_LOCK   - PLL lock indication, asynchronous to CLK
//   PLL_RESETB - PLL reset, active low
//   PLL_BYPASS - PLL bypass, high only in FAULT
//   READY      - PLL clocks valid, high only in LOCKED
//   FAULT      - retries exhausted
//   LOL_EVENT  - one-cycle pulse on loss of lock while LOCKED
//   RETRY_CNT  - timeouts since the last lock or restart
//   STATE      - current state encoding
// -----------------------------------------------------------------------------
module dphy_pll_mgr
  import dphy_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_FILT    = DEF_LOCK_FILT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            RESTART,
  input  logic                            PLL_LOCK,
  output logic                            PLL_RESETB,
  output logic                            PLL_BYPASS,
  output logic                            READY,
  output logic                            FAULT,
  output logic                            LOL_EVENT,
  output logic [retry_w(MAX_RETRY)-1:0]   RETRY_CNT,
  output logic [2:0]                      STATE
);

  localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_FILT) + 1);
  localparam int RW = retry_w(MAX_RETRY);

  logic          lock_s;
  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [RW-1:0] retry_reg;
  pll_ctl_t      ctl_reg;
  logic          lol_reg;

  dphy_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (CLK),
    .resetn (RESET),
    .d      (PLL_LOCK),
    .q      (lock_s)
  );

  // Every transition loads ctl_reg with the levels of the state being entered,
  // so all outputs change on the same edge as STATE.
  always_ff @(posedge CLK) begin
    lol_reg <= 1'b0;
    if (!RESET || RESTART) begin
      state_reg <= ST_RST_HOLD;
      cnt_reg   <= '0;
      retry_reg <= '0;
      ctl_reg   <= ctl_for(ST_RST_HOLD);
    end else begin
      case (state_reg)
        ST_RST_HOLD: begin
          if (cnt_reg == CW'(RST_CYCLES - 1)) begin
            state_reg <= ST_WAIT_LOCK;
            cnt_reg   <= '0;
            ctl_reg   <= ctl_for(ST_WAIT_LOCK);
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_reg <= ST_FILTER;
            cnt_reg   <= '0;
            ctl_reg   <= ctl_for(ST_FILTER);
          end else if (cnt_reg == CW'(LOCK_TIMEOUT - 1)) begin
            cnt_reg <= '0;
            if (int'(retry_reg) < MAX_RETRY) begin
              retry_reg <= retry_reg + 1'b1;
              state_reg <= ST_RST_HOLD;
              ctl_reg   <= ctl_for(ST_RST_HOLD);
            end else begin
              state_reg <= ST_FAULT;
              ctl_reg   <= ctl_for(ST_FAULT);
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        // The counter tallies filtered lock cycles; LOCKED is entered on the
        // lock cycle after it reaches LOCK_FILT, which puts READY at
        // SYNC_STAGES+LOCK_FILT+1 edges after PLL_LOCK is first sampled.
        ST_FILTER: begin
          if (!lock_s) begin
            state_reg <= ST_WAIT_LOCK;
            cnt_reg   <= '0;
            ctl_reg   <= ctl_for(ST_WAIT_LOCK);
          end else if (cnt_reg == CW'(LOCK_FILT)) begin
            state_reg <= ST_LOCKED;
            cnt_reg   <= '0;
            retry_reg <= '0;
            ctl_reg   <= ctl_for(ST_LOCKED);
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (!lock_s) begin
            lol_reg   <= 1'b1;
            state_reg <= ST_RST_HOLD;
            cnt_reg   <= '0;
            ctl_reg   <= ctl_for(ST_RST_HOLD);
          end
        end

        ST_FAULT: begin
          cnt_reg <= '0;
        end

        default: begin
          state_reg <= ST_RST_HOLD;
          cnt_reg   <= '0;
          ctl_reg   <= ctl_for(ST_RST_HOLD);
        end
      endcase
    end
  end

  assign PLL_RESETB = ctl_reg.resetb;
  assign PLL_BYPASS = ctl_reg.bypass;
  assign READY      = ctl_reg.ready;
  assign FAULT      = ctl_reg.fault;
  assign LOL_EVENT  = lol_reg;
  assign RETRY_CNT  = retry_reg;
  assign STATE      = state_reg;

endmodule

// File: tb/tb_dphy_pll_mgr.sv
// -----------------------------------------------------------------------------
// tb_dphy_pll_mgr
// Self-checking bench for dphy_pll_mgr at default parameters. A timing-rule
// reference model (phase + cycles remaining + lock history queue) is stepped
// on every edge and compared against all outputs; directed scenarios add
// explicit latency, pulse-width and retry checks.
// -----------------------------------------------------------------------------
module tb_dphy_pll_mgr;

  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int LOCK_FILT    = 64;
  localparam int MAX_RETRY    = 3;
  localparam int SYNC_STAGES  = 2;

  // Expected STATE values.
  localparam int P_HOLD   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_FILT   = 2;
  localparam int P_LOCKED = 3;
  localparam int P_FAULT  = 4;

  logic       clk = 1'b0;
  logic       rst_n, restart, pll_lock;
  logic       pll_resetb, pll_bypass, ready, fault, lol_event;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_ph, m_left, m_run, m_retries;
  bit m_lol;
  bit m_hist[$];

  always #5 clk = ~clk;

  dphy_pll_mgr #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_FILT    (LOCK_FILT),
    .MAX_RETRY    (MAX_RETRY),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .RESTART    (restart),
    .PLL_LOCK   (pll_lock),
    .PLL_RESETB (pll_resetb),
    .PLL_BYPASS (pll_bypass),
    .READY      (ready),
    .FAULT      (fault),
    .LOL_EVENT  (lol_event),
    .RETRY_CNT  (retry_cnt),
    .STATE      (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear_hist();
    m_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
  endtask

  // One CLK edge of the spec rules, given the inputs present at that edge.
  task automatic model_step(input bit r_n, input bit rs, input bit lk);
    bit ls;
    m_lol = 1'b0;
    if (!r_n) begin
      m_ph = P_HOLD; m_left = RST_CYCLES; m_retries = 0;
      model_clear_hist();
      return;
    end
    ls = m_hist.pop_front();
    m_hist.push_back(lk);
    if (rs) begin
      m_ph = P_HOLD; m_left = RST_CYCLES; m_retries = 0;
      return;
    end
    case (m_ph)
      P_HOLD: begin
        m_left--;
        if (m_left == 0) begin m_ph = P_WAIT; m_left = LOCK_TIMEOUT; end
      end
      P_WAIT: begin
        if (ls) begin
          m_ph = P_FILT; m_run = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_retries < MAX_RETRY) begin
              m_retries++; m_ph = P_HOLD; m_left = RST_CYCLES;
            end else begin
              m_ph = P_FAULT;
            end
          end
        end
      end
      P_FILT: begin
        if (!ls) begin
          m_ph = P_WAIT; m_left = LOCK_TIMEOUT;
        end else begin
          m_run++;
          if (m_run == LOCK_FILT + 1) begin m_ph = P_LOCKED; m_retries = 0; end
        end
      end
      P_LOCKED: begin
        if (!ls) begin m_lol = 1'b1; m_ph = P_HOLD; m_left = RST_CYCLES; end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] exp_vec();
    bit rb;
    rb = (m_ph == P_WAIT) || (m_ph == P_FILT) || (m_ph == P_LOCKED);
    return {22'd0, 3'(m_ph), rb, m_ph == P_FAULT, m_ph == P_LOCKED,
            m_ph == P_FAULT, m_lol, 2'(m_retries)};
  endfunction

  function automatic logic [31:0] got_vec();
    return {22'd0, state, pll_resetb, pll_bypass, ready, fault, lol_event, retry_cnt};
  endfunction

  // Advance one edge: model steps at the edge, outputs compared at the negedge.
  task automatic tick();
    @(posedge clk);
    model_step(rst_n, restart, pll_lock);
    @(negedge clk);
    check("cycle", got_vec(), exp_vec());
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  32'(state), 0);
    check({tag, "_resetb"}, 32'(pll_resetb), 0);
    check({tag, "_bypass"}, 32'(pll_bypass), 0);
    check({tag, "_ready"},  32'(ready), 0);
    check({tag, "_fault"},  32'(fault), 0);
    check({tag, "_lol"},    32'(lol_event), 0);
    check({tag, "_retry"},  32'(retry_cnt), 0);
  endtask

  int n, low, mask, rlen;
  bit flag_a, flag_b;

  initial begin
    rst_n = 1'b0; restart = 1'b0; pll_lock = 1'b0;
    m_ph = P_HOLD; m_left = RST_CYCLES; m_run = 0; m_retries = 0; m_lol = 1'b0;
    model_clear_hist();

    // Reset state.
    repeat (3) tick();
    check_reset_values("reset");
    $display("txn reset: state=%0d resetb=%0b", state, pll_resetb);

    // Release, lock 100 cycles after PLL_RESETB rises, measure READY latency.
    rst_n = 1'b1;
    n = 0;
    while (!pll_resetb && n < 100) begin tick(); n++; end
    check("hold_len", n, RST_CYCLES);
    repeat (100) tick();
    pll_lock = 1'b1;
    flag_a = 1'b0;
    tick();
    n = 0;
    while (!ready && n < 200) begin tick(); n++; flag_a |= lol_event; end
    check("lock_latency", n, SYNC_STAGES + LOCK_FILT + 1);
    check("lock_retry", 32'(retry_cnt), 0);
    check("lock_no_lol", 32'(flag_a), 0);
    $display("txn lock: ready after %0d edges", n);

    // Loss of lock in LOCKED.
    repeat (5) tick();
    pll_lock = 1'b0;
    n = 0;
    while (!lol_event && n < 10) begin tick(); n++; end
    check("lol_pulse", 32'(lol_event), 1);
    check("lol_ready", 32'(ready), 0);
    low = pll_resetb ? 0 : 1;
    tick();
    check("lol_width", 32'(lol_event), 0);
    while (!pll_resetb && low < 100) begin low++; tick(); end
    check("lol_hold_len", low, RST_CYCLES);
    $display("txn lol: resetb low for %0d cycles", low);

    // Short lock during FILTER falls back to WAIT_LOCK.
    pll_lock = 1'b1;
    flag_a = 1'b0; flag_b = 1'b0;
    repeat (30) begin tick(); flag_a |= ready; flag_b |= lol_event; end
    pll_lock = 1'b0;
    repeat (6) begin tick(); flag_a |= ready; flag_b |= lol_event; end
    check("filt_state", 32'(state), P_WAIT);
    check("filt_ready", 32'(flag_a), 0);
    check("filt_lol", 32'(flag_b), 0);
    check("filt_retry", 32'(retry_cnt), m_retries);
    $display("txn filter_drop: state=%0d retry=%0d", state, retry_cnt);

    // No lock at all: retries 1..3 then FAULT.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n = 0; mask = 0;
    while (!fault && n < 20000) begin tick(); n++; mask |= (1 << retry_cnt); end
    check("fault_reached", 32'(fault), 1);
    check("fault_edges_in_range",
          32'((n >= 4 * (RST_CYCLES + LOCK_TIMEOUT)) && (n <= 4 * (RST_CYCLES + LOCK_TIMEOUT) + 8)), 1);
    check("fault_retry_seq", 32'(mask[3:1]), 3'b111);
    check("fault_bypass", 32'(pll_bypass), 1);
    check("fault_retry", 32'(retry_cnt), MAX_RETRY);
    repeat (20) tick();
    check("fault_held", {pll_resetb, pll_bypass, ready, fault}, 4'b0101);
    $display("txn fault: after %0d edges", n);

    // RESTART out of FAULT.
    restart = 1'b1; tick(); restart = 1'b0;
    check("restart_fault", 32'(fault), 0);
    check("restart_bypass", 32'(pll_bypass), 0);
    check("restart_retry", 32'(retry_cnt), 0);
    check("restart_state", 32'(state), P_HOLD);
    $display("txn restart_from_fault: state=%0d", state);

    // RESTART on the very edge of a WAIT_LOCK timeout (after one retry).
    n = 0;
    while (!(m_ph == P_WAIT && m_left == 1 && m_retries == 1) && n < 10000) begin tick(); n++; end
    check("restart_to_found", 32'(m_ph == P_WAIT && m_left == 1), 1);
    check("restart_to_pre_retry", 32'(retry_cnt), 1);
    restart = 1'b1; tick(); restart = 1'b0;
    check("restart_to_state", 32'(state), P_HOLD);
    check("restart_to_retry", 32'(retry_cnt), 0);
    $display("txn restart_at_timeout: state=%0d retry=%0d", state, retry_cnt);

    // RESET mid-FILTER, then a clean relock.
    pll_lock = 1'b1;
    n = 0;
    while (!(m_ph == P_FILT && m_run >= 10) && n < 200) begin tick(); n++; end
    check("midfilt_state", 32'(state), P_FILT);
    rst_n = 1'b0; tick();
    check_reset_values("midfilt_rst");
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 300) begin tick(); n++; end
    check("relock_ready", 32'(ready), 1);
    $display("txn reset_mid_filter: relocked after %0d edges", n);

    // Random lock bursts with occasional RESTART / RESET, checked per cycle.
    rlen = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rlen == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        rlen = $urandom_range(1, 120);
      end
      rlen--;
      restart = ($urandom_range(0, 249) == 0);
      rst_n   = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1; restart = 1'b0;
    $display("txn random: 4000 cycles, state=%0d", state);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dphy_pll_mgr.md
DPHY_PLL_MGR -- requirements
Module: dphy_pll_mgr

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RST_CYCLES, 16, PLL_RESETB low-hold length in CLK cycles (>=1).
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry (>=1).
- LOCK_FILT, 64, consecutive synchronised-lock cycles required before READY (>=1).
- MAX_RETRY, 3, timeouts tolerated before FAULT; 0 means the first timeout faults.
- SYNC_STAGES, 2, flops in the PLL_LOCK synchroniser (>=2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, free-running reference clock; the only clock.
- RESET, in, 1, synchronous, active-low block reset.
- RESTART, in, 1, single-cycle request to restart the lock sequence.
- PLL_LOCK, in, 1, PLL LOCK output; asynchronous to CLK.
- PLL_RESETB, out, 1, drives PLL RESETB; active low.
- PLL_BYPASS, out, 1, drives PLL BYPASS.
- READY, out, 1, PLL clocks valid for the D-PHY datapath.
- FAULT, out, 1, retries exhausted.
- LOL_EVENT, out, 1, one-cycle pulse on loss of lock from LOCKED.
- RETRY_CNT, out, clog2(MAX_RETRY+1), timeouts since the last lock or restart.
- STATE, out, 3, current state encoding.

Function
REQ-003 PLL_LOCK SHALL pass through SYNC_STAGES flops to give lock_s; no other logic SHALL sample PLL_LOCK.
REQ-004 The FSM SHALL have states RST_HOLD, WAIT_LOCK, FILTER, LOCKED and FAULT, and one shared counter of width clog2(max(RST_CYCLES,LOCK_TIMEOUT,LOCK_FILT)+1).
REQ-005 RST_HOLD SHALL hold PLL_RESETB=0 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with the counter at 0.
REQ-006 WAIT_LOCK SHALL set PLL_RESETB=1.
- lock_s=1: enter FILTER with the counter at 0.
- After LOCK_TIMEOUT cycles without lock: if RETRY_CNT<MAX_RETRY, increment RETRY_CNT and enter RST_HOLD; otherwise enter FAULT.
REQ-007 FILTER SHALL leave on the first cycle with lock_s=0 and re-enter WAIT_LOCK with a fresh timeout. It SHALL NOT pulse LOL_EVENT or change RETRY_CNT.
REQ-008 After LOCK_FILT consecutive lock_s=1 cycles in FILTER, the FSM SHALL enter LOCKED, register READY=1 and clear RETRY_CNT.
REQ-009 Latency: READY SHALL rise exactly SYNC_STAGES+LOCK_FILT+1 CLK edges after the first edge sampling PLL_LOCK=1 in WAIT_LOCK, provided PLL_LOCK stays high.
REQ-010 LOCKED with lock_s=0 SHALL:
- pulse LOL_EVENT for exactly one cycle;
- drop READY on the same edge;
- enter RST_HOLD;
- leave RETRY_CNT unchanged.
REQ-011 FAULT SHALL hold PLL_RESETB=0, PLL_BYPASS=1, FAULT=1 and READY=0 until RESTART or RESET.
REQ-012 RESTART=1 in any state SHALL, on the next edge, enter RST_HOLD with counter=0, RETRY_CNT=0, FAULT=0, PLL_BYPASS=0 and READY=0. RESTART SHALL override every other transition, including a simultaneous timeout or loss of lock.
REQ-013 Outputs SHALL be registered. PLL_BYPASS SHALL be 1 only in FAULT. READY SHALL be 1 only in LOCKED.
REQ-014 STATE SHALL encode RST_HOLD=0, WAIT_LOCK=1, FILTER=2, LOCKED=3, FAULT=4.

Reset
REQ-015 RESET=0 sampled on a CLK edge SHALL force, from that edge:
- STATE=RST_HOLD, counter=0, synchroniser flops=0;
- PLL_RESETB=0, PLL_BYPASS=0, READY=0, FAULT=0, LOL_EVENT=0, RETRY_CNT=0.
REQ-016 RESET SHALL take priority over RESTART and SHALL abort any state mid-count; no partial count SHALL survive.

Structure
REQ-017 A shared package dphy_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-018 The synchroniser SHALL be a sub-module, dphy_sync, parametrised by SYNC_STAGES. The PLL primitive SHALL be instantiated by the parent, not inside this block.

Verification (default parameters)
REQ-019 Reset release, then PLL_LOCK rises 100 cycles after PLL_RESETB rises -> READY=1 exactly 67 edges later; RETRY_CNT=0; LOL_EVENT stays 0.
REQ-020 PLL_LOCK held at 0 -> three RST_HOLD/WAIT_LOCK cycles (RETRY_CNT 1,2,3), then FAULT=1 and PLL_BYPASS=1 after 4*(16+4096) cycles plus the FSM transition edges.
REQ-021 PLL_LOCK high for 30 cycles then low during FILTER -> STATE returns to 1, READY and LOL_EVENT stay 0, and RETRY_CNT is unchanged.
REQ-022 In LOCKED, PLL_LOCK drops -> LOL_EVENT=1 for one cycle, READY=0, then PLL_RESETB=0 for exactly 16 cycles.
REQ-023 In FAULT, RESTART pulsed -> next edge FAULT=0, PLL_BYPASS=0, RETRY_CNT=0, STATE=0. RESTART coinciding with a WAIT_LOCK timeout -> STATE=0 and RETRY_CNT=0.
REQ-024 RESET=0 asserted mid-FILTER -> all outputs at REQ-015 values on that edge; the sequence restarts cleanly on release.
